// File: rtl/ip_tx_proto_arb_if.sv
// Header + data stream bundle for the IP TX protocol arbiter; N lanes wide on the
// source side, one lane on the merged IP TX side.
interface ip_tx_proto_arb_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned DATA_W = 256
);
    localparam int unsigned IP_W  = 32;
    localparam int unsigned LEN_W = 16;

    logic [N-1:0]        hdr_val;
    logic [N*IP_W-1:0]   hdr_src_ip;
    logic [N*IP_W-1:0]   hdr_dst_ip;
    logic [N*LEN_W-1:0]  hdr_len;
    logic [N-1:0]        hdr_rdy;
    logic [N-1:0]        data_val;
    logic [N-1:0]        data_last;
    logic [N*DATA_W-1:0] data;
    logic [N-1:0]        data_rdy;

    modport master (
        output hdr_val, hdr_src_ip, hdr_dst_ip, hdr_len,
        input  hdr_rdy,
        output data_val, data_last, data,
        input  data_rdy
    );

    modport slave (
        input  hdr_val, hdr_src_ip, hdr_dst_ip, hdr_len,
        output hdr_rdy,
        input  data_val, data_last, data,
        output data_rdy
    );
endinterface

// File: rtl/ip_tx_proto_arb.sv
// Round-robin per-packet arbiter merging NUM_SRC protocol engines onto one IP TX path
// and stamping the IP protocol field. Optional per-source packet counters: IP_TX_ARB_STATS_EN.
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif
`ifndef IPPROTO_UDP
`define IPPROTO_UDP 8'h11
`endif
`ifndef IPPROTO_TCP
`define IPPROTO_TCP 8'h06
`endif

module ip_tx_proto_arb #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned SRC_ID_W = $clog2(NUM_SRC),
    parameter int unsigned DATA_W   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    ip_tx_proto_arb_if.slave       src,
    ip_tx_proto_arb_if.master      ip_tx,
    output logic [`PROTOCOL_W-1:0] ip_tx_hdr_proto,
    input  logic                   cfg_wr_val,
    input  logic [SRC_ID_W-1:0]    cfg_wr_idx,
    input  logic [`PROTOCOL_W-1:0] cfg_wr_proto
`ifdef IP_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]  stat_pkt_cnt
`endif
);
    localparam int unsigned PROTO_W = `PROTOCOL_W;
    localparam int unsigned IP_W    = 32;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned CNT_W   = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [SRC_ID_W-1:0] grant_q, grant_d;
    logic [SRC_ID_W-1:0] last_grant_q, last_grant_d;
    logic [PROTO_W-1:0]  proto_q, proto_d;
    logic [PROTO_W-1:0]  proto_tbl [NUM_SRC];

    logic                arb_found;
    logic [SRC_ID_W-1:0] arb_idx;
    logic [NUM_SRC-1:0]  gsel;
    logic [LEN_W-1:0]    cur_len;
    logic                cur_last;
    logic                hdr_hs;
    logic                data_hs;

    // Granted-source field mux; header and data are pure pass-through
    assign ip_tx.hdr_src_ip = src.hdr_src_ip[32'(grant_q)*IP_W +: IP_W];
    assign ip_tx.hdr_dst_ip = src.hdr_dst_ip[32'(grant_q)*IP_W +: IP_W];
    assign ip_tx.hdr_len    = src.hdr_len[32'(grant_q)*LEN_W +: LEN_W];
    assign ip_tx.data       = src.data[32'(grant_q)*DATA_W +: DATA_W];
    assign ip_tx_hdr_proto  = proto_q;

    assign cur_len  = src.hdr_len[32'(grant_q)*LEN_W +: LEN_W];
    assign cur_last = src.data_last[grant_q];
    assign hdr_hs   = (state_q == S_HDR)  && src.hdr_val[grant_q]  && ip_tx.hdr_rdy[0];
    assign data_hs  = (state_q == S_DATA) && src.data_val[grant_q] && ip_tx.data_rdy[0];

    // Round-robin search starting one past the last granted source
    always_comb begin
        int unsigned k;
        k         = 0;
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            k = (32'(last_grant_q) + i) % NUM_SRC;
            if (!arb_found && src.hdr_val[SRC_ID_W'(k)]) begin
                arb_found = 1'b1;
                arb_idx   = SRC_ID_W'(k);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        proto_d      = proto_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    proto_d = proto_tbl[arb_idx];
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (hdr_hs) begin
                    last_grant_d = grant_q;
                    state_d      = (cur_len == LEN_W'(0)) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (data_hs && cur_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake steering: only the granted source ever sees a ready
    always_comb begin
        gsel             = '0;
        gsel[grant_q]    = 1'b1;
        ip_tx.hdr_val    = 1'b0;
        ip_tx.data_val   = 1'b0;
        ip_tx.data_last  = 1'b0;
        src.hdr_rdy      = '0;
        src.data_rdy     = '0;
        if (state_q == S_HDR) begin
            ip_tx.hdr_val = src.hdr_val[grant_q];
            src.hdr_rdy   = gsel & {NUM_SRC{ip_tx.hdr_rdy[0]}};
        end
        if (state_q == S_DATA) begin
            ip_tx.data_val  = src.data_val[grant_q];
            ip_tx.data_last = src.data_last[grant_q];
            src.data_rdy    = gsel & {NUM_SRC{ip_tx.data_rdy[0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_ID_W'(NUM_SRC - 1);
            proto_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            proto_q      <= proto_d;
        end
    end

    // Protocol table; out-of-range indices match no entry and are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                proto_tbl[i] <= (i == 0) ? PROTO_W'(`IPPROTO_UDP) : PROTO_W'(`IPPROTO_TCP);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (cfg_wr_val && (32'(cfg_wr_idx) == i)) begin
                    proto_tbl[i] <= cfg_wr_proto;
                end
            end
        end
    end

`ifdef IP_TX_ARB_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q [NUM_SRC];
    logic             pkt_done;

    assign pkt_done = (hdr_hs && (cur_len == LEN_W'(0))) || (data_hs && cur_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (pkt_done && (32'(grant_q) == i)) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stat_pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            stat_pkt_cnt[i*CNT_W +: CNT_W] = pkt_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_ip_tx_proto_arb.sv
// Directed scoreboard bench for ip_tx_proto_arb with two protocol engines.
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif

module tb_ip_tx_proto_arb;
    localparam int unsigned NS = 2;
    localparam int unsigned DW = 256;
    localparam int unsigned PW = `PROTOCOL_W;

    typedef logic [0:0] sid_t;
    typedef struct packed {
        logic [31:0]   sip;
        logic [31:0]   dip;
        logic [15:0]   len;
        logic [PW-1:0] proto;
    } hdr_t;
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct packed {
        sid_t              src;
        hdr_t              h;
        int                nbeats;
        logic [3:0][DW-1:0] beats;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ip_tx_proto_arb_if #(.N(NS), .DATA_W(DW)) src_bus ();
    ip_tx_proto_arb_if #(.N(1),  .DATA_W(DW)) tx_bus ();

    logic [PW-1:0] proto;
    logic          cfg_wr_val;
    logic [0:0]    cfg_wr_idx;
    logic [PW-1:0] cfg_wr_proto;
`ifdef IP_TX_ARB_STATS_EN
    logic [NS*32-1:0] stat;
`endif

    ip_tx_proto_arb #(.NUM_SRC(NS), .SRC_ID_W(1), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .src             (src_bus),
        .ip_tx           (tx_bus),
        .ip_tx_hdr_proto (proto),
        .cfg_wr_val      (cfg_wr_val),
        .cfg_wr_idx      (cfg_wr_idx),
        .cfg_wr_proto    (cfg_wr_proto)
`ifdef IP_TX_ARB_STATS_EN
        ,
        .stat_pkt_cnt    (stat)
`endif
    );

    logic          hv [NS];
    logic          dv [NS];
    logic          dl [NS];
    logic [31:0]   sip [NS];
    logic [31:0]   dip [NS];
    logic [15:0]   ln [NS];
    logic [DW-1:0] dd [NS];

    assign src_bus.hdr_val    = {hv[1], hv[0]};
    assign src_bus.hdr_src_ip = {sip[1], sip[0]};
    assign src_bus.hdr_dst_ip = {dip[1], dip[0]};
    assign src_bus.hdr_len    = {ln[1], ln[0]};
    assign src_bus.data_val   = {dv[1], dv[0]};
    assign src_bus.data_last  = {dl[1], dl[0]};
    assign src_bus.data       = {dd[1], dd[0]};

    hdr_t  hq [$];
    sid_t  hsrc_q [$];
    beat_t bq [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    sid_t  cur_src = 1'b0;
    int    tag_n = 0;

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(input sid_t s, input int len, input logic [PW-1:0] pr);
        pkt_t p;
        tag_n++;
        p.src     = s;
        p.h.sip   = {8'(s) + 8'd1, 8'h0A, 16'(tag_n)};
        p.h.dip   = 32'hC0A8_0000 + 32'(tag_n);
        p.h.len   = 16'(len);
        p.h.proto = pr;
        p.nbeats  = (len + 31) / 32;
        for (int b = 0; b < 4; b++) begin
            p.beats[2'(b)] = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
        end
        return p;
    endfunction

    task automatic push(input pkt_t p);
        hq.push_back(p.h);
        hsrc_q.push_back(p.src);
        for (int b = 0; b < p.nbeats; b++) begin
            bq.push_back({(b == p.nbeats - 1), p.beats[2'(b)]});
        end
    endtask

    // Holds the current val until the DUT returns ready; returns at posedge+1 after handshake
    task automatic wait_hs(input sid_t s, input bit data_ph, input string tag);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = data_ph ? src_bus.data_rdy[s] : src_bus.hdr_rdy[s];
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        assert (hs) else begin
            n_bad++;
            $error("FAIL timeout_%s: src %0d saw no ready in %0d cycles", tag, s, n);
        end
    endtask

    task automatic drive_pkt(input pkt_t p);
        sid_t s;
        s      = p.src;
        sip[s] = p.h.sip;
        dip[s] = p.h.dip;
        ln[s]  = p.h.len;
        hv[s]  = 1'b1;
        wait_hs(s, 1'b0, "hdr");
        hv[s] = 1'b0;
        for (int b = 0; b < p.nbeats; b++) begin
            dd[s] = p.beats[2'(b)];
            dl[s] = (b == p.nbeats - 1);
            dv[s] = 1'b1;
            wait_hs(s, 1'b1, "data");
        end
        if (p.nbeats > 0) begin
            dv[s] = 1'b0;
            dl[s] = 1'b0;
        end
    endtask

    // Pops expectations on every merged handshake
    task automatic monitor();
        hdr_t  eh;
        beat_t eb;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_bus.hdr_val[0] && tx_bus.hdr_rdy[0]) begin
                    n_cmp++;
                    assert (hq.size() != 0) else begin
                        n_bad++;
                        $error("FAIL hdr_unexpected: observed sip %0h expected none", tx_bus.hdr_src_ip);
                    end
                    if (hq.size() != 0) begin
                        eh      = hq.pop_front();
                        cur_src = hsrc_q.pop_front();
                        chk("hdr", 264'({tx_bus.hdr_src_ip, tx_bus.hdr_dst_ip, tx_bus.hdr_len, proto}),
                            264'(eh));
                    end
                end
                if (tx_bus.data_val[0]) begin
                    chk("data_rdy_mirror", 264'(src_bus.data_rdy),
                        264'((2'b01 << cur_src) & {2{tx_bus.data_rdy[0]}}));
                    if (tx_bus.data_rdy[0]) begin
                        n_cmp++;
                        assert (bq.size() != 0) else begin
                            n_bad++;
                            $error("FAIL beat_unexpected: observed %0h expected none", tx_bus.data);
                        end
                        if (bq.size() != 0) begin
                            eb = bq.pop_front();
                            chk("beat", 264'({tx_bus.data_last, tx_bus.data}), 264'(eb));
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((hq.size() != 0 || bq.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({"drain_", tag}, 264'({hq.size(), bq.size()}), 264'(0));
    endtask

    initial begin
        pkt_t    p0 [3];
        pkt_t    p1 [3];
        pkt_t    a, b, c, d, e, f, g, h0, h1;
        logic [3:0] pat;

        pat = 4'b1001;
        rst = 1'b1;
        hv = '{default: 1'b0};
        dv = '{default: 1'b0};
        dl = '{default: 1'b0};
        sip = '{default: 32'h0};
        dip = '{default: 32'h0};
        ln = '{default: 16'h0};
        dd = '{default: '0};
        tx_bus.hdr_rdy  = 1'b1;
        tx_bus.data_rdy = 1'b1;
        cfg_wr_val   = 1'b0;
        cfg_wr_idx   = 1'b0;
        cfg_wr_proto = '0;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vals", 264'({tx_bus.hdr_val, tx_bus.data_val, src_bus.hdr_rdy, src_bus.data_rdy}), 264'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_proto", 264'(proto), 264'(0));
`ifdef IP_TX_ARB_STATS_EN
        chk("stat_rst", 264'(stat), 264'(0));
`endif
        @(posedge clk);
        #1;

        // Both sources request together: strict alternation starting at src0
        p0[0] = mk(1'b0, 32, 8'h11);  p1[0] = mk(1'b1, 64, 8'h06);
        p0[1] = mk(1'b0, 96, 8'h11);  p1[1] = mk(1'b1, 32, 8'h06);
        p0[2] = mk(1'b0, 64, 8'h11);  p1[2] = mk(1'b1, 128, 8'h06);
        for (int i = 0; i < 3; i++) begin
            push(p0[i]);
            push(p1[i]);
        end
        fork
            begin for (int i = 0; i < 3; i++) drive_pkt(p0[i]); end
            begin for (int i = 0; i < 3; i++) drive_pkt(p1[i]); end
        join
        wait_drain("rr");
`ifdef IP_TX_ARB_STATS_EN
        chk("stat_rr", 264'(stat), 264'({32'd3, 32'd3}));
`endif

        // Single src0 packet, then one idle arbitration cycle before the next header
        a = mk(1'b0, 64, 8'h11);
        b = mk(1'b0, 32, 8'h11);
        push(a);
        push(b);
        drive_pkt(a);
        fork
            drive_pkt(b);
            begin
                @(negedge clk);
                chk("idle_gap", 264'({src_bus.hdr_rdy, tx_bus.hdr_val, tx_bus.data_val}), 264'(0));
                @(negedge clk);
                chk("hdr_after_gap", 264'(src_bus.hdr_rdy), 264'(2'b01));
            end
        join
        wait_drain("single");

        // Downstream backpressure 1,0,0,1
        c = mk(1'b0, 128, 8'h11);
        push(c);
        fork
            drive_pkt(c);
            begin
                for (int i = 0; i < 24; i++) begin
                    tx_bus.data_rdy = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        tx_bus.data_rdy = 1'b1;
        wait_drain("bp");

        // Table write during a src1 packet: current packet keeps TCP, next carries 0x01
        tx_bus.data_rdy = 1'b0;
        d = mk(1'b1, 64, 8'h06);
        push(d);
        fork
            drive_pkt(d);
            begin
                repeat (5) @(posedge clk);
                #1;
                cfg_wr_val   = 1'b1;
                cfg_wr_idx   = 1'b1;
                cfg_wr_proto = 8'h01;
                @(posedge clk);
                #1;
                cfg_wr_val      = 1'b0;
                tx_bus.data_rdy = 1'b1;
            end
        join
        e = mk(1'b1, 32, 8'h01);
        push(e);
        drive_pkt(e);
        wait_drain("cfg");

        // Zero-length header from src1 with a beat pending: nothing consumed
        f = mk(1'b1, 0, 8'h01);
        push(f);
        dd[1] = {8{32'hDEAD_BEEF}};
        dl[1] = 1'b1;
        dv[1] = 1'b1;
        drive_pkt(f);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_no_data", 264'({src_bus.data_rdy, tx_bus.data_val}), 264'(0));
        end
        @(posedge clk);
        #1;
        dv[1] = 1'b0;
        dl[1] = 1'b0;
        wait_drain("len0");
`ifdef IP_TX_ARB_STATS_EN
        chk("stat_len0", 264'(stat), 264'({32'd6, 32'd6}));
`endif

        // Reset while src0 is in its data phase
        g = mk(1'b0, 64, 8'h11);
        hq.push_back(g.h);
        hsrc_q.push_back(1'b0);
        tx_bus.data_rdy = 1'b0;
        sip[0] = g.h.sip;
        dip[0] = g.h.dip;
        ln[0]  = g.h.len;
        hv[0]  = 1'b1;
        wait_hs(1'b0, 1'b0, "rst_hdr");
        hv[0] = 1'b0;
        dd[0] = g.beats[0];
        dv[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst             = 1'b1;
        tx_bus.data_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_pkt", 264'({tx_bus.hdr_val, tx_bus.data_val, src_bus.hdr_rdy, src_bus.data_rdy}), 264'(0));
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        rst   = 1'b0;
`ifdef IP_TX_ARB_STATS_EN
        @(negedge clk);
        chk("stat_after_rst", 264'(stat), 264'(0));
        @(posedge clk);
        #1;
`endif
        h0 = mk(1'b0, 32, 8'h11);
        h1 = mk(1'b1, 32, 8'h06);
        push(h0);
        push(h1);
        fork
            drive_pkt(h0);
            drive_pkt(h1);
        join
        wait_drain("post_rst");
`ifdef IP_TX_ARB_STATS_EN
        chk("stat_end", 264'(stat), 264'({32'd1, 32'd1}));
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
